uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200); legal range >= 4.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame.
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rx  input  1  serial line, asynchronous to clk, idle high.
REQ-006 SHALL have port full  input  1  downstream FIFO full indication.
REQ-007 SHALL have port o_data  output  DATA_WIDTH  last received byte.
REQ-008 SHALL have port push  output  1  one-cycle write strobe to the FIFO.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when a good byte is dropped because full=1.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rxs.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, BRK.
REQ-014 IDLE: rxs==0 -> START, bit-timer cleared.
REQ-015 START: at timer == CLKS_PER_BIT/2-1 (integer division), sample rxs.
- rxs==0 -> DATA, timer and bit index cleared.
- rxs==1 -> IDLE, glitch rejected, no outputs.
REQ-016 DATA: at timer == CLKS_PER_BIT-1, sample rxs into the shift register LSB first and clear the timer; after bit index DATA_WIDTH-1 -> STOP.
REQ-017 STOP: at timer == CLKS_PER_BIT-1, sample rxs.
- rxs==1 and full==0 -> load o_data, push=1 for one cycle, -> IDLE.
- rxs==1 and full==1 -> overrun=1 for one cycle, o_data unchanged, no push, -> IDLE.
- rxs==0 -> frame_err=1 for one cycle, no push, o_data unchanged, -> BRK.
REQ-018 BRK: stay while rxs==0; rxs==1 -> IDLE (a line break yields exactly one frame_err).
REQ-019 o_data SHALL update only in the cycle push asserts and hold otherwise; it is valid while push is high.
REQ-020 push, frame_err and overrun SHALL be mutually exclusive and never high for two consecutive cycles.
REQ-021 Bit timer width SHALL be $clog2(CLKS_PER_BIT); the bit index SHALL never exceed DATA_WIDTH-1.
REQ-022 Latency: push SHALL assert 2 + CLKS_PER_BIT/2 + (DATA_WIDTH+1)*CLKS_PER_BIT cycles after the first clk edge that sees rx low (+/-1 cycle).
REQ-023 A new start bit directly after the stop-bit sample SHALL be accepted: the IDLE -> START transition occurs in the cycle after the return to IDLE.
REQ-024 full SHALL be sampled only at the stop-bit decision; its value at other times has no effect.

Reset
REQ-025 rst high SHALL force, asynchronously and at any point including mid-frame:
- state IDLE; timer, bit index and shift register to 0;
- synchronizer flops to 1;
- o_data 0; push, frame_err, overrun, busy all 0.
REQ-026 After rst deasserts, the block SHALL ignore a frame already in progress until it sees rxs==1 then 0.

Structure
REQ-027 Package uart_pkg SHALL hold the state encoding (3-bit localparams) and the default CLKS_PER_BIT, shared with the UART transmitter.
REQ-028 The synchronizer SHALL be sub-module uart_sync2 (1-bit, async reset-to-1); all remaining logic stays in uart_rx.

Verification (CLKS_PER_BIT=16, DATA_WIDTH=8)
REQ-029 Frame 0xA5 with a good stop bit and full=0 -> exactly one push, o_data=0xA5, no frame_err or overrun.
REQ-030 rx low for 4 cycles, then high -> no push, no frame_err, busy back to 0 within 12 cycles.
REQ-031 Frame 0x3C with stop bit 0, then rx held low 40 cycles and released -> one frame_err, no push, o_data unchanged, busy=0 after release.
REQ-032 full=1 during frame 0x55 -> one overrun pulse, no push; next frame 0x81 with full=0 -> push with o_data=0x81.
REQ-033 Back-to-back 0x00 then 0xFF with no idle gap -> two pushes, data 0x00 then 0xFF.
REQ-034 rst pulsed during bit 3 of a frame -> all outputs 0 immediately; the remainder of that frame produces no push.

Source files
------------

// File: rtl/uart_pkg.sv
// Purpose: shared UART definitions (receiver/transmitter state encoding, default bit timing).
// Latency: n/a, constants and types only.
// Backpressure: n/a.
//
// Contents:
//   UART_CLKS_PER_BIT  default clk cycles per serial bit (50 MHz / 115200)
//   ST_*               3-bit state codes, reused by the transmitter
//   uart_state_e       enum view of the same codes for FSM registers
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 434;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BRK   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_STOP  = ST_STOP,
    S_BRK   = ST_BRK
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Purpose: 2-flop synchronizer for a single asynchronous line that idles high.
// Latency: 2 clk cycles from d_i to q_o.
// Backpressure: none, free-running.
//
// Ports:
//   clk  system clock          rst  async active-high reset, both flops go to 1
//   d_i  asynchronous input    q_o  synchronized output
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Reset to 1 so a held reset looks like an idle line, not a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Purpose: UART receiver, 1 start / DATA_WIDTH data (LSB first) / 1 stop bit, mid-bit sampling.
// Latency: push 2 + CLKS_PER_BIT/2 + (DATA_WIDTH+1)*CLKS_PER_BIT cycles after rx falls.
// Backpressure: full sampled only at the stop-bit decision; a good byte seen while full is dropped with an overrun pulse.
//
// Ports:
//   clk, rst              clock and async active-high reset
//   rx                    serial line, asynchronous, idle high
//   full                  downstream FIFO full
//   o_data                last accepted byte, updates only with push
//   push                  one-cycle FIFO write strobe
//   frame_err             one-cycle pulse on a low stop bit
//   overrun               one-cycle pulse when a good byte is dropped due to full
//   busy                  high whenever the FSM is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  full,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  push,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);

  logic rxs;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rxs)
  );

  uart_state_e           state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [IW-1:0]         idx_q,   idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic                  push_q,  push_d;
  logic                  ferr_q,  ferr_d;
  logic                  ovr_q,   ovr_d;
  logic [1:0]            arm_q,   arm_d;
  logic                  armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      arm_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      push_q  <= push_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      arm_q   <= arm_d;
    end
  end

  // The synchronizer's reset value is not a real observation of the line.
  // Three consecutive high samples guarantee at least one genuine idle-high
  // sample, so a frame already in flight when reset drops is ignored until
  // the line has been seen high and then falls again.
  assign armed = (arm_q == 2'd3);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    push_d  = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    arm_d   = arm_q;

    if (!armed) begin
      arm_d = rxs ? (arm_q + 2'd1) : 2'd0;
    end

    case (state_q)
      S_IDLE: begin
        if (armed && !rxs) begin
          state_d = S_START;
          timer_d = '0;
        end
      end

      // Sample mid start bit; a line already back high was a glitch.
      S_START: begin
        if (timer_q == HALF_LAST) begin
          if (!rxs) begin
            state_d = S_DATA;
            timer_d = '0;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      // LSB arrives first: shift right and insert at the MSB.
      S_DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d                 = '0;
          shift_d                 = shift_q >> 1;
          shift_d[DATA_WIDTH-1]   = rxs;
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (rxs) begin
            state_d = S_IDLE;
            if (full) begin
              ovr_d = 1'b1;
            end else begin
              push_d = 1'b1;
              data_d = shift_q;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BRK;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      // Line held low past the stop bit: wait for release so a break
      // reports a single frame error.
      S_BRK: begin
        if (rxs) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_data    = data_q;
  assign push      = push_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DW  = 8;
  localparam int LAT = 2 + CPB / 2 + (DW + 1) * CPB;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          full;
  logic [DW-1:0] o_data;
  logic          push;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .full      (full),
    .o_data    (o_data),
    .push      (push),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  typedef enum int {EV_PUSH = 0, EV_FERR = 1, EV_OVR = 2} ev_e;

  typedef struct {
    ev_e         kind;
    logic [7:0]  dat;
    int          t0;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop_b;
    logic       full_v;
    int         low_after;
    int         idle_after;
    ev_e        kind;
    logic [7:0] exp_d;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[6];

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n_push   = 0;
  int   n_ferr   = 0;
  int   n_ovr    = 0;
  logic prev_evt = 1'b0;
  ev_e  m_kind;
  exp_t m_exp;
  int   pre_total;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard consumer: every output pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      prev_evt = 1'b0;
    end else if (push || frame_err || overrun) begin
      check(int'(push) + int'(frame_err) + int'(overrun) == 1, "pulse_exclusive",
            int'(push) + int'(frame_err) + int'(overrun), 1);
      check(prev_evt == 1'b0, "pulse_not_consecutive", int'(prev_evt), 0);
      m_kind = push ? EV_PUSH : (frame_err ? EV_FERR : EV_OVR);
      if (push)      n_push++;
      if (frame_err) n_ferr++;
      if (overrun)   n_ovr++;
      check(sbq.size() != 0, "unexpected_pulse", sbq.size(), 1);
      if (sbq.size() != 0) begin
        m_exp = sbq.pop_front();
        check(m_kind == m_exp.kind, "pulse_kind", int'(m_kind), int'(m_exp.kind));
        check(o_data == m_exp.dat, "o_data", int'(o_data), int'(m_exp.dat));
        check((cyc - m_exp.t0 >= LAT - 1) && (cyc - m_exp.t0 <= LAT + 1), "latency",
              cyc - m_exp.t0, LAT);
      end
      prev_evt = 1'b1;
    end else begin
      prev_evt = 1'b0;
    end
  end

  // Entered and left on a falling clock edge so frames can run back to back.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic full_v,
                            input ev_e k, input logic [7:0] exp_d);
    exp_t e;
    full   = full_v;
    rx     = 1'b0;
    e.kind = k;
    e.dat  = exp_d;
    e.t0   = cyc + 1;
    sbq.push_back(e);
    repeat (CPB) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      rx = d[b];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_b;
    repeat (CPB) @(negedge clk);
    full = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check(o_data == 8'h00, {tag, "_o_data"}, int'(o_data), 0);
    check(push == 1'b0, {tag, "_push"}, int'(push), 0);
    check(frame_err == 1'b0, {tag, "_frame_err"}, int'(frame_err), 0);
    check(overrun == 1'b0, {tag, "_overrun"}, int'(overrun), 0);
    check(busy == 1'b0, {tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    rst  = 1'b1;
    rx   = 1'b1;
    full = 1'b0;

    tbl[0] = '{8'hA5, 1'b1, 1'b0,  0, 20, EV_PUSH, 8'hA5};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 40, 20, EV_FERR, 8'hA5};
    tbl[2] = '{8'h55, 1'b1, 1'b1,  0, 20, EV_OVR,  8'hA5};
    tbl[3] = '{8'h81, 1'b1, 1'b0,  0, 20, EV_PUSH, 8'h81};
    tbl[4] = '{8'h00, 1'b1, 1'b0,  0,  0, EV_PUSH, 8'h00};
    tbl[5] = '{8'hFF, 1'b1, 1'b0,  0, 20, EV_PUSH, 8'hFF};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check(busy == 1'b0, "idle_after_reset_busy", int'(busy), 0);

    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].data, tbl[i].stop_b, tbl[i].full_v, tbl[i].kind, tbl[i].exp_d);
      if (tbl[i].low_after > 0) begin
        repeat (tbl[i].low_after) @(negedge clk);
        check(busy == 1'b1, "busy_in_break", int'(busy), 1);
        rx = 1'b1;
      end
      if (tbl[i].idle_after > 0) begin
        repeat (tbl[i].idle_after) @(negedge clk);
        check(busy == 1'b0, "busy_after_frame", int'(busy), 0);
        check(sbq.size() == 0, "frame_resolved", sbq.size(), 0);
      end
    end

    // Short low glitch: START entered, then rejected at the mid-bit sample.
    pre_total = n_push + n_ferr + n_ovr;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check(busy == 1'b1, "glitch_busy", int'(busy), 1);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    check(busy == 1'b0, "glitch_busy_clear", int'(busy), 0);
    check(n_push + n_ferr + n_ovr == pre_total, "glitch_no_pulse",
          n_push + n_ferr + n_ovr, pre_total);

    // Reset in the middle of data bit 3 of frame 0xF8.
    pre_total = n_push + n_ferr + n_ovr;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    check(busy == 1'b1, "busy_before_reset", int'(busy), 1);
    #2 rst = 1'b1;
    #1 check_all_zero("midframe_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (CPB * 7) @(negedge clk);
    check(busy == 1'b0, "post_reset_busy", int'(busy), 0);
    check(o_data == 8'h00, "post_reset_o_data", int'(o_data), 0);
    check(n_push + n_ferr + n_ovr == pre_total, "post_reset_no_pulse",
          n_push + n_ferr + n_ovr, pre_total);

    // Receiver recovers normally after the reset.
    send_frame(8'h5A, 1'b1, 1'b0, EV_PUSH, 8'h5A);
    repeat (20) @(negedge clk);

    check(sbq.size() == 0, "scoreboard_drained", sbq.size(), 0);
    check(n_push == 5, "total_push", n_push, 5);
    check(n_ferr == 1, "total_frame_err", n_ferr, 1);
    check(n_ovr == 1, "total_overrun", n_ovr, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
